// File: rtl/rv_multicycle_sequencer.sv
// rv_multicycle_sequencer: PC, fetch/decode/execute/memory/writeback FSM and memory req/ack handshake.
// Optional breakpoint support is enabled by defining RV_SEQ_BREAKPOINT_EN.
module rv_multicycle_sequencer #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter logic [XLEN-1:0] MMIO_BASE   = 32'h00020000,
    parameter int              MEM_TIMEOUT = 15,
    parameter int              CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic [XLEN-1:0]  instr_rdata,
    input  logic             is_halt,
    input  logic             decode_error,
    input  logic             is_load,
    input  logic [1:0]       mem_write_size,
    input  logic             jump,
    input  logic             jal_or_jalr,
    input  logic             branch,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  immediate,
    input  logic [XLEN-1:0]  rv1,
    input  logic [XLEN-1:0]  alu_out,
    input  logic             mem_ack,
    input  logic [XLEN-1:0]  bp_addr,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    output logic [1:0]       mem_wsize,
    output logic             mmio_we,
    output logic [XLEN-1:0]  instr,
    output logic [XLEN-1:0]  pc,
    output logic             alu_latch,
    output logic             reg_we,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_FETCH      = 4'd1,
        S_WAIT_FETCH = 4'd2,
        S_DECODE     = 4'd3,
        S_EXECUTE    = 4'd4,
        S_MEM        = 4'd5,
        S_WAIT_MEM   = 4'd6,
        S_WRITEBACK  = 4'd7,
        S_BREAK      = 4'd8,
        S_HALT       = 4'd9,
        S_MEM_ERR    = 4'd13,
        S_DECODE_ERR = 4'd14
    } state_e;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d, instr_q, instr_d, mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [1:0]       mem_wsize_q, mem_wsize_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             mem_req_q, mem_req_d, mmio_we_q, mmio_we_d;
    logic             alu_latch_q, alu_latch_d, reg_we_q, reg_we_d;
    logic             is_store, mmio_store;
    logic [XLEN-1:0]  jalr_sum, next_pc;

    assign is_store   = mem_write_size != 2'd0;
    assign mmio_store = is_store && alu_out >= MMIO_BASE;
    assign jalr_sum   = rv1 + immediate;
    assign next_pc    = (jump && jal_or_jalr) || (!jump && branch && branch_taken) ? pc_q + immediate :
                        jump ? {jalr_sum[XLEN-1:1], 1'b0} : pc_q + XLEN'(4);

`ifdef RV_SEQ_BREAKPOINT_EN
    logic bp_done_q, bp_done_d;
`else
    logic unused_bp;
    assign unused_bp = ^bp_addr;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        retired_d   = retired_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wsize_d = mem_wsize_q;
        cnt_d       = cnt_q;
`ifdef RV_SEQ_BREAKPOINT_EN
        bp_done_d   = bp_done_q;
`endif
        case (state_q)
            S_IDLE:  state_d = start ? S_FETCH : S_IDLE;
            S_FETCH: begin
`ifdef RV_SEQ_BREAKPOINT_EN
                if (pc_q == bp_addr && !bp_done_q) begin
                    state_d   = S_BREAK;
                    bp_done_d = 1'b1;
                end else
`endif
                if (!step_mode || step) begin
                    mem_req_d   = 1'b1;
                    mem_addr_d  = pc_q;
                    mem_wsize_d = 2'd0;
                    cnt_d       = '0;
                    state_d     = S_WAIT_FETCH;
                end
            end
            S_WAIT_FETCH, S_WAIT_MEM: begin
                // an ack arriving on the timeout cycle still wins
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    instr_d   = state_q == S_WAIT_FETCH ? instr_rdata : instr_q;
                    state_d   = state_q == S_WAIT_FETCH ? S_DECODE : S_WRITEBACK;
                end else if (cnt_q == 8'(MEM_TIMEOUT)) begin
                    mem_req_d = 1'b0;
                    state_d   = S_MEM_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DECODE:  state_d = is_halt ? S_HALT : decode_error ? S_DECODE_ERR : S_EXECUTE;
            S_EXECUTE: state_d = (is_load || is_store) ? S_MEM : S_WRITEBACK;
            S_MEM: begin
                if (mmio_store) begin
                    state_d = S_WRITEBACK;
                end else begin
                    mem_req_d   = 1'b1;
                    mem_addr_d  = alu_out;
                    mem_wsize_d = mem_write_size;
                    cnt_d       = '0;
                    state_d     = S_WAIT_MEM;
                end
            end
            S_WRITEBACK: begin
                retired_d = retired_q + CNT_W'(1);
                pc_d      = next_pc;
                state_d   = S_FETCH;
            end
            S_BREAK:                          state_d = start ? S_FETCH : S_BREAK;
            S_HALT, S_MEM_ERR, S_DECODE_ERR:  state_d = state_q;
            default:                          state_d = S_IDLE;
        endcase
`ifdef RV_SEQ_BREAKPOINT_EN
        bp_done_d   = pc_d != pc_q ? 1'b0 : bp_done_d;
`endif
        // strobes are registered, so they are computed for the state being entered
        alu_latch_d = state_d == S_EXECUTE;
        reg_we_d    = state_d == S_WRITEBACK && !is_store && !branch;
        mmio_we_d   = state_q == S_MEM && mmio_store;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            retired_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wsize_q <= 2'd0;
            cnt_q       <= '0;
            mmio_we_q   <= 1'b0;
            alu_latch_q <= 1'b0;
            reg_we_q    <= 1'b0;
`ifdef RV_SEQ_BREAKPOINT_EN
            bp_done_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            retired_q   <= retired_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wsize_q <= mem_wsize_d;
            cnt_q       <= cnt_d;
            mmio_we_q   <= mmio_we_d;
            alu_latch_q <= alu_latch_d;
            reg_we_q    <= reg_we_d;
`ifdef RV_SEQ_BREAKPOINT_EN
            bp_done_q   <= bp_done_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wsize = mem_wsize_q;
    assign mmio_we   = mmio_we_q;
    assign instr     = instr_q;
    assign pc        = pc_q;
    assign alu_latch = alu_latch_q;
    assign reg_we    = reg_we_q;
    assign state     = state_q;
    assign retired   = retired_q;
endmodule

// File: tb/tb_rv_multicycle_sequencer.sv
// tb_rv_multicycle_sequencer: table-driven instruction vectors plus directed timeout/step/reset/breakpoint sequences.
module tb_rv_multicycle_sequencer;
    localparam logic [31:0] MAGIC = 32'hA5A50000;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, step_mode = 1'b0, step = 1'b0;
    logic [31:0] instr_rdata = '0, immediate = '0, rv1 = '0, alu_out = '0, bp_addr = 32'hFFFFFFF0;
    logic        is_halt = 1'b0, decode_error = 1'b0, is_load = 1'b0, jump = 1'b0, jal_or_jalr = 1'b0;
    logic        branch = 1'b0, branch_taken = 1'b0, mem_ack = 1'b0;
    logic [1:0]  mem_write_size = 2'd0;
    logic        mem_req, mmio_we, alu_latch, reg_we;
    logic [31:0] mem_addr, instr, pc, retired;
    logic [1:0]  mem_wsize;
    logic [3:0]  state;

    rv_multicycle_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
        .instr_rdata(instr_rdata), .is_halt(is_halt), .decode_error(decode_error),
        .is_load(is_load), .mem_write_size(mem_write_size), .jump(jump), .jal_or_jalr(jal_or_jalr),
        .branch(branch), .branch_taken(branch_taken), .immediate(immediate), .rv1(rv1),
        .alu_out(alu_out), .mem_ack(mem_ack), .bp_addr(bp_addr), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_wsize(mem_wsize), .mmio_we(mmio_we), .instr(instr), .pc(pc),
        .alu_latch(alu_latch), .reg_we(reg_we), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int ack_delay = 2, wait_cnt = 0;
    logic ack_en = 1'b1;
    int n_rwe, n_mmio, n_alu, n_dreq;
    logic [31:0] d_addr;
    logic [1:0]  d_size;
    logic        req_prev = 1'b0;
    logic [31:0] cur_pc;
    int          exp_ret;

    // memory model: ack after ack_delay idle negedges, returns address-tagged data
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (!mem_req) wait_cnt = 0;
        else if (ack_en) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack = 1'b1;
                instr_rdata = mem_addr ^ MAGIC;
            end else wait_cnt++;
        end
    end

    always @(negedge clk) begin
        n_rwe  += int'(reg_we);
        n_mmio += int'(mmio_we);
        n_alu  += int'(alu_latch);
        if (state == 4'd6 && mem_req && !req_prev) begin
            n_dreq++;
            d_addr = mem_addr;
            d_size = mem_wsize;
        end
        req_prev = mem_req;
    end

    typedef struct {
        string       name;
        logic        ld;
        logic [1:0]  ws;
        logic        jmp, jal, br, tk;
        logic [31:0] imm, rv, alu;
        int          dly;
        logic [31:0] exp_pc;
        int          exp_rwe, exp_mmio, exp_dreq;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int lim, input string nm);
        int n = 0;
        while (state !== s && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(nm, state, s);
    endtask

    task automatic drive(input vec_t t);
        is_load = t.ld; mem_write_size = t.ws; jump = t.jmp; jal_or_jalr = t.jal;
        branch = t.br; branch_taken = t.tk; immediate = t.imm; rv1 = t.rv; alu_out = t.alu;
        ack_delay = t.dly; is_halt = 1'b0; decode_error = 1'b0;
    endtask

    task automatic clr_mon();
        n_rwe = 0; n_mmio = 0; n_alu = 0; n_dreq = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; ack_en = 1'b1; step_mode = 1'b0; start = 1'b0; step = 1'b0;
        is_halt = 1'b0; decode_error = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cur_pc = 32'h0;
        exp_ret = 0;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t t);
        int  n = 0;
        logic seen_wb = 1'b0;
        drive(t);
        clr_mon();
        while (!(seen_wb && state == 4'd1) && n < 200) begin
            @(negedge clk);
            n++;
            if (state == 4'd7) seen_wb = 1'b1;
        end
        exp_ret++;
        chk({t.name, "_done"}, state, 4'd1);
        chk({t.name, "_pc"}, pc, t.exp_pc);
        chk({t.name, "_retired"}, retired, exp_ret);
        chk({t.name, "_instr"}, instr, cur_pc ^ MAGIC);
        chk({t.name, "_reg_we"}, n_rwe, t.exp_rwe);
        chk({t.name, "_mmio_we"}, n_mmio, t.exp_mmio);
        chk({t.name, "_alu_latch"}, n_alu, 1);
        chk({t.name, "_data_req"}, n_dreq, t.exp_dreq);
        if (t.exp_dreq > 0) begin
            chk({t.name, "_data_addr"}, d_addr, t.alu);
            chk({t.name, "_data_size"}, d_size, t.ws);
        end
        cur_pc = t.exp_pc;
    endtask

    initial begin
        vec_t t;
        int   n, bad;
        //          name        ld    ws    jmp   jal   br    tk    imm           rv1           alu           dly pc            rwe mmio dreq
        tbl[0]  = '{"addi",     1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5,        32'h0,        32'h0,        2,  32'h4,        1,  0,   0};
        tbl[1]  = '{"lw",       1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h100,      1,  32'h8,        1,  0,   1};
        tbl[2]  = '{"sw",       1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h200,      0,  32'hC,        0,  0,   1};
        tbl[3]  = '{"sw_mmio",  1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h00020010, 2,  32'h10,       0,  1,   0};
        tbl[4]  = '{"jal",      1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10,       32'h0,        32'h0,        2,  32'h20,       1,  0,   0};
        tbl[5]  = '{"beq_tk",   1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFF8, 32'h0,        32'h0,        2,  32'h18,       0,  0,   0};
        tbl[6]  = '{"bne_nt",   1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40,       32'h0,        32'h0,        2,  32'h1C,       0,  0,   0};
        tbl[7]  = '{"jalr",     1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4,        32'h103,      32'h0,        2,  32'h106,      1,  0,   0};
        tbl[8]  = '{"jalr_wrap",1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3,        32'hFFFFFFFF, 32'h0,        1,  32'h2,        1,  0,   0};
        tbl[9]  = '{"jal_back", 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h0,        32'h0,        0,  32'h0,        1,  0,   0};
        tbl[10] = '{"sb_below", 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0001FFFF, 2,  32'h4,        0,  0,   1};
        tbl[11] = '{"sb_base",  1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h00020000, 2,  32'h8,        0,  1,   0};
        tbl[12] = '{"lw_mmio",  1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h00020000, 3,  32'hC,        1,  0,   1};
        tbl[13] = '{"lw_ack_to",1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h40,       15, 32'h10,       1,  0,   1};
        tbl[14] = '{"jal_vs_br",1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h8,        32'h0,        32'h0,        2,  32'h18,       0,  0,   0};

        do_reset();
        chk("rst_state", state, 4'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_strobes", {mem_req, mmio_we, alu_latch, reg_we}, 4'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wsize", mem_wsize, 2'd0);
        repeat (3) @(negedge clk);
        chk("idle_wait", state, 4'd0);

        // small program: two ADDIs then a halt word
        start_run();
        chk("start_fetch", state, 4'd1);
        run_vec(tbl[0]);
        t = tbl[0]; t.exp_pc = 32'h8;
        run_vec(t);
        is_halt = 1'b1;
        wait_state(4'd9, 20, "halt_state");
        chk("halt_instr", instr, 32'h8 ^ MAGIC);
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        chk("halt_sticky", state, 4'd9);
        chk("halt_pc", pc, 32'h8);
        chk("halt_retired", retired, 32'd2);

        do_reset();
        start_run();
        for (int i = 0; i < 15; i++) run_vec(tbl[i]);
        decode_error = 1'b1;
        wait_state(4'd14, 20, "decerr_state");
        repeat (3) @(negedge clk);
        chk("decerr_sticky", state, 4'd14);
        chk("decerr_pc", pc, cur_pc);
        chk("decerr_retired", retired, exp_ret);

        // fetch that is never acknowledged
        do_reset();
        drive(tbl[0]);
        ack_en = 1'b0;
        start_run();
        wait_state(4'd2, 5, "to_wait_fetch");
        n = 0; bad = 0;
        while (state == 4'd2 && n < 40) begin
            if (mem_req !== 1'b1) bad++;
            @(negedge clk);
            n++;
        end
        chk("to_cycles", n, 16);
        chk("to_state", state, 4'd13);
        chk("to_req_held", bad, 0);
        chk("to_pc", pc, 32'h0);
        repeat (3) @(negedge clk);
        chk("to_sticky", state, 4'd13);
        chk("to_retired", retired, 32'd0);

        // single step: one instruction per pulse
        do_reset();
        drive(tbl[0]);
        step_mode = 1'b1;
        start_run();
        repeat (20) @(negedge clk);
        chk("step_hold_state", state, 4'd1);
        chk("step_hold_retired", retired, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            repeat (20) @(negedge clk);
            chk("step_state", state, 4'd1);
            chk("step_retired", retired, k);
            chk("step_pc", pc, 32'(4 * k));
        end

        // reset while a store is outstanding
        do_reset();
        t = tbl[2]; t.dly = 10;
        drive(t);
        start_run();
        wait_state(4'd6, 30, "rst_mid_wait_mem");
        clr_mon();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_state", state, 4'd0);
        chk("rst_mid_req", mem_req, 1'b0);
        chk("rst_mid_wsize", mem_wsize, 2'd0);
        chk("rst_mid_pc", pc, 32'h0);
        repeat (12) @(negedge clk);
        chk("rst_mid_idle", state, 4'd0);
        chk("rst_mid_writes", n_rwe + n_mmio, 0);
        chk("rst_mid_retired", retired, 32'd0);

`ifdef RV_SEQ_BREAKPOINT_EN
        do_reset();
        bp_addr = 32'h8;
        start_run();
        run_vec(tbl[0]);
        t = tbl[0]; t.exp_pc = 32'h8;
        run_vec(t);
        wait_state(4'd8, 5, "bp_state");
        repeat (3) @(negedge clk);
        chk("bp_hold", state, 4'd8);
        chk("bp_pc", pc, 32'h8);
        chk("bp_retired", retired, 32'd2);
        chk("bp_no_req", mem_req, 1'b0);
        start_run();
        t.exp_pc = 32'hC;
        run_vec(t);
        repeat (3) @(negedge clk);
        chk("bp_no_rebreak", state == 4'd8, 1'b0);
        chk("bp_after_retired", retired, 32'd3);
        bp_addr = 32'hFFFFFFF0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv_multicycle_sequencer.md
Name: rv_multicycle_sequencer

Overview:
Parametrised control sequencer for the multi-cycle RISC-V core. It owns the program counter, the fetch/decode/execute/memory/writeback state machine and the memory request handshake.
- Replaces fixed-latency memory wait states with a req/ack handshake plus a timeout.
- Skips the memory phase for non-memory instructions.
- Adds single-step and a retired-instruction counter.
- Sits between the instruction decoder, register file, ALU, byte-addressable memory and the ASCII VGA controller.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 0, PC value loaded on reset
MMIO_BASE, 32'h00020000, addresses >= this are routed to mmio_we instead of memory
MEM_TIMEOUT, 15, max cycles waiting for mem_ack before MEM_ERR (1..255)
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
start  in  1  leave IDLE / resume from BREAK
step_mode  in  1  1 = wait for step before each fetch
step  in  1  single-cycle pulse, releases one instruction in step_mode
instr_rdata  in  XLEN  fetched word from memory
is_halt  in  1  decoder: opcode 7'b1111111
decode_error  in  1  decoder error flag
is_load  in  1  decoder: mem_to_reg
mem_write_size  in  2  decoder store size (0 = none)
jump  in  1  decoder jump
jal_or_jalr  in  1  1 = JAL (pc-relative), 0 = JALR
branch  in  1  decoder branch
branch_taken  in  1  branch comparator result
immediate  in  XLEN  decoded immediate
rv1  in  XLEN  register rs1 value
alu_out  in  XLEN  effective address / ALU result
mem_ack  in  1  memory completed request (1-cycle pulse)
bp_addr  in  XLEN  breakpoint address (see optional feature)
mem_req  out  1  memory request, held until ack
mem_addr  out  XLEN  request address
mem_wsize  out  2  write size for current request (0 = read)
mmio_we  out  1  1-cycle VGA/MMIO write strobe
instr  out  XLEN  latched instruction
pc  out  XLEN  program counter
alu_latch  out  1  1-cycle strobe: datapath latches ALU operands
reg_we  out  1  1-cycle register-file write enable
state  out  4  current state (for LEDs)
retired  out  CNT_W  instructions completed

Behaviour:
- Reset (rst=1 at posedge clk) has priority over everything. Values after reset:
  - state=IDLE, pc=RESET_PC, instr=0, retired=0.
  - All strobes 0, mem_req=0, mem_addr=0, mem_wsize=0, timeout counter 0.
  - Reset mid-handshake abandons the request; no write is issued.
- State encodings: IDLE 0, FETCH 1, WAIT_FETCH 2, DECODE 3, EXECUTE 4, MEM 5, WAIT_MEM 6, WRITEBACK 7, BREAK 8, HALT 9, MEM_ERR 13, DECODE_ERR 14. Any other value goes to IDLE next cycle.
- IDLE: start=1 -> FETCH.
- FETCH:
  - If step_mode=1 and step=0, stay in FETCH.
  - Otherwise set mem_req=1, mem_addr=pc, mem_wsize=0, clear the timeout counter, go to WAIT_FETCH.
- WAIT_FETCH:
  - mem_ack=1 -> latch instr=instr_rdata, drop mem_req, go to DECODE.
  - Counter reaches MEM_TIMEOUT -> MEM_ERR.
  - Otherwise stay and increment the counter.
- DECODE, priority order:
  - is_halt -> HALT.
  - decode_error -> DECODE_ERR.
  - else EXECUTE.
- EXECUTE: alu_latch=1 for this cycle.
  - is_load or mem_write_size!=0 -> MEM.
  - else -> WRITEBACK.
- MEM, priority order:
  - Store with alu_out >= MMIO_BASE (unsigned): no request, go to WRITEBACK.
  - Otherwise set mem_req=1, mem_addr=alu_out, mem_wsize=mem_write_size, clear the counter, go to WAIT_MEM.
- WAIT_MEM: same ack/timeout rules as WAIT_FETCH, then WRITEBACK.
- WRITEBACK, one cycle, then FETCH:
  - reg_we=1 unless mem_write_size!=0 or branch=1.
  - mmio_we=1 if this is an MMIO store.
  - retired increments and wraps modulo 2^CNT_W.
  - pc update, XLEN-bit wrapping adds, first match wins:
    - jump & jal_or_jalr -> pc+immediate.
    - jump & ~jal_or_jalr -> (rv1+immediate) with bit 0 cleared.
    - branch & branch_taken -> pc+immediate.
    - else pc+4.
- HALT, DECODE_ERR, MEM_ERR: terminal. pc and retired frozen; only reset exits.
- mem_ack outside WAIT_FETCH/WAIT_MEM is ignored.
- An ack in the same cycle the counter reaches MEM_TIMEOUT counts as success.
- step pulses outside FETCH are ignored; each pulse releases at most one instruction.

Optional Feature:
- Macro: RV_SEQ_BREAKPOINT_EN.
- Defined: in FETCH, before the step check, pc==bp_addr and the breakpoint not yet consumed for this pc -> BREAK, with no request issued.
  - BREAK holds until start=1, then returns to FETCH and fetches bp_addr normally.
  - The consumed flag clears when pc changes.
- Not defined: bp_addr is ignored and BREAK is unreachable.

Test Plan:
1. Reset, start=1; memory acks every fetch after 2 cycles; program ADDI, ADDI, halt word 0x0000007F -> HALT with retired=2, pc=8, state=9.
2. Memory never acks, MEM_TIMEOUT=15 -> MEM_ERR exactly 16 cycles after entering WAIT_FETCH; mem_req=1 throughout, pc unchanged.
3. SW to 0x00020010 -> mem_req stays 0 in MEM, mmio_we pulses once in WRITEBACK, reg_we=0, pc+=4.
4. JALR with rv1=0x103, immediate=4 -> pc=0x106, reg_we=1. Taken BEQ at pc=0x20, immediate=-8 -> pc=0x18.
5. step_mode=1, three step pulses 20 cycles apart -> retired advances by exactly 1 per pulse and sequencer idles in FETCH between pulses. rst asserted in WAIT_MEM -> IDLE, no write.
6. RV_SEQ_BREAKPOINT_EN, bp_addr=0x8 -> state=8 with pc=0x8 and retired=2; start=1 -> instruction at 0x8 executes once, no re-break.
